// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and parity-mode codes,
// used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // Code 2'b11 is treated like PAR_NONE.
    function automatic logic par_enabled(input logic [1:0] mode);
        logic en;
        case (mode)
            PAR_EVEN, PAR_ODD: en = 1'b1;
            PAR_NONE:          en = 1'b0;
            default:           en = 1'b0;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Small synchronous FIFO with first-word fall-through read data.
// A write while full is dropped even if a pop happens in the same cycle.
module uart_fifo #(
    parameter int DBIT    = 8,
    parameter int FIFO_AW = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr,
    input  logic            rd,
    input  logic [DBIT-1:0] w_data,
    output logic [DBIT-1:0] r_data,
    output logic            full,
    output logic            empty
);

    localparam int DEPTH = 2 ** FIFO_AW;

    logic [DBIT-1:0]    mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               wr_ok, rd_ok;

    assign full   = (count_q == (FIFO_AW + 1)'(DEPTH));
    assign empty  = (count_q == '0);
    assign r_data = mem_q[rd_ptr_q];

    always_comb begin
        wr_ok    = wr && !full;
        rd_ok    = rd && !empty;
        wr_ptr_d = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= w_data;
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// UART transmitter with transmit FIFO, optional even/odd parity and
// configurable oversampling and stop length; frames run back to back.
module uart_tx_param #(
    parameter int DBIT    = 8,
    parameter int OS      = 16,
    parameter int SB_TICK = 16,
    parameter int FIFO_AW = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            wr_en,
    input  logic [DBIT-1:0] din,
    input  logic [1:0]      par_mode,
    output logic            full,
    output logic            empty,
    output logic            tx_busy,
    output logic            tx_done_tick,
    output logic            tx
);

    import uart_pkg::*;

    localparam int S_MAX = (OS > SB_TICK) ? OS : SB_TICK;
    localparam int SW    = $clog2(S_MAX);
    localparam int NW    = $clog2(DBIT);
    localparam logic [SW-1:0] OS_LAST = SW'(OS - 1);
    localparam logic [SW-1:0] SB_LAST = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST  = NW'(DBIT - 1);

    uart_state_e     state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] sh_q, sh_d;
    logic            par_bit_q, par_bit_d;
    logic            par_en_q, par_en_d;
    logic            pend_q, pend_d;
    logic            done_q, done_d;
    logic            tx_q, tx_d;
    logic            pop;
    logic [DBIT-1:0] fifo_rdata;

    uart_fifo #(
        .DBIT    (DBIT),
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr     (wr_en),
        .rd     (pop),
        .w_data (din),
        .r_data (fifo_rdata),
        .full   (full),
        .empty  (empty)
    );

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        n_d       = n_q;
        sh_d      = sh_q;
        par_bit_d = par_bit_q;
        par_en_d  = par_en_q;
        pend_d    = pend_q;
        done_d    = 1'b0;
        pop       = 1'b0;
        case (state_q)
            // From IDLE the word is loaded one edge before START is entered.
            ST_IDLE: begin
                if (pend_q) begin
                    state_d = ST_START;
                    s_d     = '0;
                    pend_d  = 1'b0;
                end else if (!empty) begin
                    pop    = 1'b1;
                    pend_d = 1'b1;
                end
            end
            ST_START: if (s_tick) begin
                if (s_q == OS_LAST) begin
                    state_d = ST_DATA;
                    s_d     = '0;
                    n_d     = '0;
                end else begin
                    s_d = s_q + 1'b1;
                end
            end
            ST_DATA: if (s_tick) begin
                if (s_q == OS_LAST) begin
                    s_d  = '0;
                    sh_d = sh_q >> 1;
                    if (n_q == N_LAST) begin
                        state_d = par_en_q ? ST_PARITY : ST_STOP;
                    end else begin
                        n_d = n_q + 1'b1;
                    end
                end else begin
                    s_d = s_q + 1'b1;
                end
            end
            ST_PARITY: if (s_tick) begin
                if (s_q == OS_LAST) begin
                    state_d = ST_STOP;
                    s_d     = '0;
                end else begin
                    s_d = s_q + 1'b1;
                end
            end
            ST_STOP: if (s_tick) begin
                if (s_q == SB_LAST) begin
                    done_d = 1'b1;
                    s_d    = '0;
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    s_d = s_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (pop) begin
            sh_d      = fifo_rdata;
            par_en_d  = par_enabled(par_mode);
            par_bit_d = (^fifo_rdata) ^ (par_mode == PAR_ODD);
        end
        // tx is registered from the next state so it changes with the state.
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = sh_d[0];
            ST_PARITY: tx_d = par_bit_d;
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            s_q       <= '0;
            n_q       <= '0;
            sh_q      <= '0;
            par_bit_q <= 1'b0;
            par_en_q  <= 1'b0;
            pend_q    <= 1'b0;
            done_q    <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            n_q       <= n_d;
            sh_q      <= sh_d;
            par_bit_q <= par_bit_d;
            par_en_q  <= par_en_d;
            pend_q    <= pend_d;
            done_q    <= done_d;
            tx_q      <= tx_d;
        end
    end

    assign tx_busy      = (state_q != ST_IDLE);
    assign tx_done_tick = done_q;
    assign tx           = tx_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: two instances (8N/parity with 16-tick stop, and
// 5-bit with 32-tick stop) checked against a per-tick frame model.
module tb_uart_tx_param;

    localparam int OS = 16;

    logic       clk, reset, s_tick, tick_en, mon_en;
    logic       wr_en0, wr_en1;
    logic [7:0] din0;
    logic [4:0] din1;
    logic [1:0] par_mode0, par_mode1;
    logic       full0, empty0, busy0, done0, tx0;
    logic       full1, empty1, busy1, done1, tx1;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected frames: {back_to_back, par_mode, data}
    logic [11:0] exp_q0[$];
    logic [11:0] exp_q1[$];
    logic        active[2];
    logic        done_pend[2];
    int          pos[2];
    int          gap[2];
    logic [11:0] cur_e[2];

    uart_tx_param dut0 (
        .clk (clk), .reset (reset), .s_tick (s_tick), .wr_en (wr_en0),
        .din (din0), .par_mode (par_mode0), .full (full0), .empty (empty0),
        .tx_busy (busy0), .tx_done_tick (done0), .tx (tx0)
    );

    uart_tx_param #(.DBIT(5), .OS(16), .SB_TICK(32), .FIFO_AW(2)) dut1 (
        .clk (clk), .reset (reset), .s_tick (s_tick), .wr_en (wr_en1),
        .din (din1), .par_mode (par_mode1), .full (full1), .empty (empty1),
        .tx_busy (busy1), .tx_done_tick (done1), .tx (tx1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        s_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            s_tick = tick_en && ($urandom_range(0, 3) != 0);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic par_on(input logic [1:0] m);
        return (m == 2'b01) || (m == 2'b10);
    endfunction

    function automatic int frame_len(input logic [1:0] m, input int db, input int sb);
        return (1 + db + (par_on(m) ? 1 : 0)) * OS + sb;
    endfunction

    // Line level expected on the pos-th s_tick of a frame.
    function automatic logic exp_bit(input logic [8:0] d, input logic [1:0] m, input int db, input int p);
        int bi;
        bi = p / OS;
        if (bi == 0) return 1'b0;
        if (bi <= db) return d[bi-1];
        if (par_on(m) && bi == db + 1) return (^d) ^ (m == 2'b10);
        return 1'b1;
    endfunction

    task automatic mon_step(input int id, input logic tx_v, input logic done_v, input logic busy_v);
        int          db, sb;
        logic [11:0] e;
        db = (id == 0) ? 8 : 5;
        sb = (id == 0) ? 16 : 32;
        if (done_pend[id]) begin
            check_eq("done_pulse", {31'b0, done_v}, 1);
            done_pend[id] = 1'b0;
        end else if (done_v !== 1'b0) begin
            check_eq("spurious_done", {31'b0, done_v}, 0);
        end
        if (!s_tick) return;
        if (!active[id]) begin
            if (tx_v === 1'b1) begin
                gap[id]++;
                return;
            end
            e = '0;
            if (id == 0 && exp_q0.size() > 0) e = exp_q0.pop_front();
            else if (id == 1 && exp_q1.size() > 0) e = exp_q1.pop_front();
            else check_eq("unexpected_start", {31'b0, tx_v}, 1);
            if (e[11]) check_eq("stop_to_start_gap", gap[id], 0);
            check_eq("busy_in_frame", {31'b0, busy_v}, 1);
            cur_e[id]  = e;
            active[id] = 1'b1;
            pos[id]    = 0;
        end
        check_eq(id == 0 ? "tx_bit_dut0" : "tx_bit_dut1", {31'b0, tx_v},
                 {31'b0, exp_bit(cur_e[id][8:0], cur_e[id][10:9], db, pos[id])});
        pos[id]++;
        if (pos[id] == frame_len(cur_e[id][10:9], db, sb)) begin
            active[id]    = 1'b0;
            gap[id]       = 0;
            done_pend[id] = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon_step(0, tx0, done0, busy0);
            mon_step(1, tx1, done1, busy1);
        end
    end

    // Caller is at a negedge; returns one negedge later with wr_en dropped.
    task automatic do_write(input int id, input logic [8:0] d, input logic [1:0] m,
                            input logic b2b, input logic acc);
        if (id == 0) begin
            wr_en0 = 1'b1; din0 = d[7:0]; par_mode0 = m;
            if (acc) exp_q0.push_back({b2b, m, d});
        end else begin
            wr_en1 = 1'b1; din1 = d[4:0]; par_mode1 = m;
            if (acc) exp_q1.push_back({b2b, m, d});
        end
        @(negedge clk);
        wr_en0 = 1'b0;
        wr_en1 = 1'b0;
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 20000 && !ok; i++) begin
            @(negedge clk);
            ok = !busy0 && !busy1 && empty0 && empty1 && exp_q0.size() == 0 &&
                 exp_q1.size() == 0 && !active[0] && !active[1] &&
                 !done_pend[0] && !done_pend[1];
        end
        check_eq("idle_timeout", {31'b0, ok}, 1);
    endtask

    task automatic check_reset_state();
        check_eq("rst_tx0", {31'b0, tx0}, 1);
        check_eq("rst_empty0", {31'b0, empty0}, 1);
        check_eq("rst_full0", {31'b0, full0}, 0);
        check_eq("rst_busy0", {31'b0, busy0}, 0);
        check_eq("rst_done0", {31'b0, done0}, 0);
        check_eq("rst_tx1", {31'b0, tx1}, 1);
        check_eq("rst_empty1", {31'b0, empty1}, 1);
        check_eq("rst_busy1", {31'b0, busy1}, 0);
    endtask

    initial begin
        logic ok;
        int   burst, db;
        logic [1:0] m;
        logic [8:0] d;
        reset = 1'b0; tick_en = 1'b0; mon_en = 1'b0;
        wr_en0 = 1'b0; wr_en1 = 1'b0; din0 = '0; din1 = '0;
        par_mode0 = 2'b00; par_mode1 = 2'b00;
        for (int i = 0; i < 2; i++) begin
            active[i] = 1'b0; done_pend[i] = 1'b0; pos[i] = 0; gap[i] = 0; cur_e[i] = '0;
        end
        repeat (3) @(negedge clk);
        check_reset_state();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;

        // Write into empty idle FIFO: START exactly two edges after the write edge.
        do_write(0, 9'h055, 2'b00, 1'b0, 1'b1);
        check_eq("lat_e1_tx", {31'b0, tx0}, 1);
        check_eq("lat_e1_empty", {31'b0, empty0}, 0);
        @(negedge clk);
        check_eq("lat_e2_tx", {31'b0, tx0}, 1);
        check_eq("lat_e2_empty", {31'b0, empty0}, 1);
        @(negedge clk);
        check_eq("lat_e3_tx", {31'b0, tx0}, 0);
        check_eq("lat_e3_busy", {31'b0, busy0}, 1);
        tick_en = 1'b1;
        wait_idle();

        // Even parity on 0x07, then par_mode changed mid-frame to none.
        do_write(0, 9'h007, 2'b01, 1'b0, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = active[0];
        end
        check_eq("start_timeout", {31'b0, ok}, 1);
        par_mode0 = 2'b00;
        wait_idle();
        do_write(0, 9'h007, 2'b10, 1'b0, 1'b1);
        wait_idle();

        // Three words back to back.
        do_write(0, 9'h011, 2'b00, 1'b0, 1'b1);
        do_write(0, 9'h022, 2'b00, 1'b1, 1'b1);
        do_write(0, 9'h033, 2'b00, 1'b1, 1'b1);
        wait_idle();

        // Ticks held off: one word popped, four stored, sixth dropped.
        tick_en = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            do_write(0, 9'(8'h80 + i), 2'b00, (i != 0), (i < 5));
        end
        check_eq("fill_full", {31'b0, full0}, 1);
        check_eq("fill_empty", {31'b0, empty0}, 0);
        repeat (3) @(negedge clk);
        check_eq("hold_full", {31'b0, full0}, 1);
        check_eq("hold_tx", {31'b0, tx0}, 0);
        tick_en = 1'b1;
        wait_idle();

        // 5-bit instance: 0x1F with even parity and a 32-tick stop.
        do_write(1, 9'h01F, 2'b01, 1'b0, 1'b1);
        wait_idle();

        // Reset during data bit 3 with more words queued.
        do_write(0, 9'h0A5, 2'b01, 1'b0, 1'b1);
        do_write(0, 9'h03C, 2'b01, 1'b1, 1'b1);
        do_write(0, 9'h099, 2'b01, 1'b1, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk);
            ok = active[0] && pos[0] >= 4 * OS + 3 && pos[0] < 5 * OS;
        end
        check_eq("bit3_timeout", {31'b0, ok}, 1);
        mon_en = 1'b0;
        reset  = 1'b0;
        @(negedge clk);
        check_eq("midrst_tx", {31'b0, tx0}, 1);
        check_eq("midrst_empty", {31'b0, empty0}, 1);
        check_eq("midrst_busy", {31'b0, busy0}, 0);
        check_eq("midrst_done", {31'b0, done0}, 0);
        reset = 1'b1;
        exp_q0.delete();
        active[0] = 1'b0; done_pend[0] = 1'b0; pos[0] = 0; gap[0] = 0;
        @(negedge clk);
        check_eq("postrst_done", {31'b0, done0}, 0);
        mon_en = 1'b1;
        repeat (400) @(negedge clk);
        check_eq("postrst_empty", {31'b0, empty0}, 1);

        // Random bursts on both instances.
        for (int r = 0; r < 8; r++) begin
            for (int id = 0; id < 2; id++) begin
                burst = $urandom_range(1, 3);
                m     = 2'($urandom_range(0, 3));
                db    = (id == 0) ? 8 : 5;
                for (int k = 0; k < burst; k++) begin
                    d = 9'($urandom_range(0, (1 << db) - 1));
                    do_write(id, d, m, (k != 0), 1'b1);
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
            end
            wait_idle();
        end
        check_eq("final_empty0", {31'b0, empty0}, 1);
        check_eq("final_tx1", {31'b0, tx1}, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 SHALL have parameter DBIT, default 8: data bits per frame, legal 5..9.
REQ-002 SHALL have parameter OS, default 16: s_tick pulses per data/start/parity bit.
REQ-003 SHALL have parameter SB_TICK, default 16: s_tick pulses for the stop period (OS, 1.5*OS, or 2*OS).
REQ-004 SHALL have parameter FIFO_AW, default 2: transmit FIFO depth = 2**FIFO_AW words.
REQ-005 SHALL have port clk, input, 1: single rising-edge clock for all state.
REQ-006 SHALL have port reset, input, 1: reset, synchronous and active-low.
REQ-007 SHALL have port s_tick, input, 1: one-clk-wide oversampling enable from the baud generator.
REQ-008 SHALL have port wr_en, input, 1: FIFO write strobe.
REQ-009 SHALL have port din, input, DBIT: word to transmit, LSB first.
REQ-010 SHALL have port par_mode, input, 2: 00 none, 01 even, 10 odd, 11 none.
REQ-011 SHALL have port full, output, 1: FIFO holds 2**FIFO_AW words.
REQ-012 SHALL have port empty, output, 1: FIFO holds 0 words.
REQ-013 SHALL have port tx_busy, output, 1: FSM not in IDLE.
REQ-014 SHALL have port tx_done_tick, output, 1: one-clk pulse at frame completion.
REQ-015 SHALL have port tx, output, 1: registered serial line, idle high.

Function
REQ-016 SHALL write din to the FIFO on a clk edge with wr_en=1 and full=0; with full=1 the write is dropped, contents unchanged, even if a pop occurs in the same cycle.
REQ-017 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, with tick counter s (0..max(OS,SB_TICK)-1) and bit counter n (0..DBIT-1).
REQ-018 In IDLE with empty=0, SHALL pop one word, latch it into a shift register, latch par_mode, and enter START on the next edge with s=0.
REQ-019 A write into an empty FIFO while in IDLE SHALL cause START entry exactly 2 clk edges after the write edge.
REQ-020 tx SHALL be 0 from START entry, carry shift-register bit 0 throughout DATA, the parity bit throughout PARITY, and 1 in STOP and IDLE.
REQ-021 s SHALL advance only on cycles with s_tick=1; with s_tick=0 the FSM, counters and tx SHALL hold.
REQ-022 START, each DATA bit, and PARITY SHALL each last exactly OS s_ticks; the transition occurs on the s_tick cycle with s=OS-1, resetting s to 0.
REQ-023 At each DATA bit end, SHALL shift right by 1 and increment n; after bit n=DBIT-1, SHALL go to PARITY if latched mode is even/odd, else STOP.
REQ-024 Parity bit SHALL equal XOR of the DBIT data bits (even) or its complement (odd), computed from the popped word.
REQ-025 par_mode changes after the pop SHALL NOT affect the frame in progress.
REQ-026 STOP SHALL last SB_TICK s_ticks; on the s_tick cycle with s=SB_TICK-1, tx_done_tick=1 for that single cycle.
REQ-027 At STOP end with empty=0, SHALL pop and enter START directly (no IDLE cycle, no gap beyond the stop period); with empty=1, SHALL enter IDLE.
REQ-028 tx_busy SHALL be 1 in START, DATA, PARITY and STOP.
REQ-029 FIFO read and write pointers SHALL wrap modulo 2**FIFO_AW; full and empty SHALL derive from a FIFO_AW+1-bit count or an extra pointer bit.

Reset
REQ-030 On a clk edge with reset=0: state=IDLE, s=0, n=0, shift register=0, FIFO pointers=0, tx=1, tx_done_tick=0, tx_busy=0, empty=1, full=0.
REQ-031 Reset mid-frame SHALL abandon the frame, flush the FIFO, force tx=1 at that edge, and SHALL NOT produce tx_done_tick.

Structure
REQ-032 State encodings and par_mode codes (PAR_NONE, PAR_EVEN, PAR_ODD) SHALL live in the shared UART package/include, reused by the receiver.
REQ-033 The FIFO SHALL be a separate sub-module uart_fifo (parameters DBIT, FIFO_AW) that the receiver can reuse.

Verification
REQ-034 DBIT=8, OS=16, par 00, write 0x55 -> tx = 0,1,0,1,0,1,0,1,0,1 with 16 s_ticks per bit; one tx_done_tick after the 160th s_tick.
REQ-035 par 01, write 0x07 -> parity bit 1; par 10, write 0x07 -> parity bit 0; frame length 176 s_ticks.
REQ-036 Write 0x11, 0x22, 0x33 on consecutive clks -> three frames with tx never high between the stop bit and the next start bit beyond SB_TICK; three done pulses.
REQ-037 s_tick held 0, FIFO_AW=2, write 6 words on consecutive clks -> first word popped, next 4 stored, full=1, 6th dropped; 5 frames total.
REQ-038 reset=0 asserted during DATA bit 3 -> tx=1 at that edge, empty=1, tx_busy=0, no tx_done_tick.
REQ-039 DBIT=5, SB_TICK=32, write 0x1F par 01 -> 5 data ones, parity 1, stop high for 32 s_ticks.
